// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: serialises mepc/mcause/mstatus updates for traps and MRET,
// owns the CSR write port, and keeps shadow copies of mstatus, mie, mtvec and mepc.
module trap_ctrl #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [XLEN-1:0]   exc_cause,
    input  logic [XLEN-1:0]   exc_epc,
    input  logic              irq_ext,
    input  logic              irq_sw,
    input  logic              irq_tim,
    input  logic [XLEN-1:0]   cur_pc,
    input  logic              mret_valid,
    input  logic              pipe_csr_we,
    input  logic [CSR_AW-1:0] pipe_csr_waddr,
    input  logic [XLEN-1:0]   pipe_csr_wdata,
    output logic              csr_write,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              stall,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MIE     = CSR_AW'(12'h304);
    localparam logic [CSR_AW-1:0] ADDR_MTVEC   = CSR_AW'(12'h305);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

    localparam logic [3:0] CODE_EXT = 4'd11;
    localparam logic [3:0] CODE_SW  = 4'd3;
    localparam logic [3:0] CODE_TIM = 4'd7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        E_EPC   = 3'd1,
        E_CAUSE = 3'd2,
        E_STAT  = 3'd3,
        R_STAT  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] mstatus_sh, mie_sh, mtvec_sh, mepc_sh;

    logic [XLEN-1:0] lat_cause, lat_epc;
    logic            lat_intr;
    logic [3:0]      lat_code;

    logic            irq_take;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;

    logic            accept_trap;
    logic            accept_intr;
    logic [XLEN-1:0] accept_cause;
    logic [XLEN-1:0] accept_epc;

    logic [XLEN-1:0] trap_status;
    logic [XLEN-1:0] mret_status;
    logic [XLEN-1:0] vec_base;
    logic [XLEN-1:0] vec_target;

    // Fixed priority ext > sw > tim, gated by the global enable in mstatus.MIE.
    always_comb begin
        irq_take = 1'b0;
        irq_code = 4'd0;
        if (mstatus_sh[3]) begin
            if (irq_ext && mie_sh[11]) begin
                irq_take = 1'b1;
                irq_code = CODE_EXT;
            end else if (irq_sw && mie_sh[3]) begin
                irq_take = 1'b1;
                irq_code = CODE_SW;
            end else if (irq_tim && mie_sh[7]) begin
                irq_take = 1'b1;
                irq_code = CODE_TIM;
            end
        end
        irq_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};
    end

    always_comb begin
        trap_status        = mstatus_sh;
        trap_status[7]     = mstatus_sh[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;

        mret_status        = mstatus_sh;
        mret_status[3]     = mstatus_sh[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b11;
    end

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    always_comb begin
        vec_base   = {mtvec_sh[XLEN-1:2], 2'b00};
        vec_target = vec_base;
        if (mtvec_sh[1:0] == 2'b01 && lat_intr)
            vec_target = vec_base + XLEN'({lat_code, 2'b00});
    end

    always_comb begin
        state_d        = state_q;
        csr_write      = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        accept_trap    = 1'b0;
        accept_intr    = 1'b0;
        accept_cause   = '0;
        accept_epc     = '0;

        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    accept_trap  = 1'b1;
                    accept_cause = exc_cause;
                    accept_epc   = exc_epc;
                    stall        = 1'b1;
                    state_d      = E_EPC;
                end else if (irq_take) begin
                    accept_trap  = 1'b1;
                    accept_intr  = 1'b1;
                    accept_cause = irq_cause;
                    accept_epc   = cur_pc;
                    stall        = 1'b1;
                    state_d      = E_EPC;
                end else if (mret_valid) begin
                    stall   = 1'b1;
                    state_d = R_STAT;
                end else begin
                    csr_write = pipe_csr_we;
                    csr_waddr = pipe_csr_waddr;
                    csr_wdata = pipe_csr_wdata;
                end
            end
            E_EPC: begin
                stall     = 1'b1;
                csr_write = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = lat_epc;
                state_d   = E_CAUSE;
            end
            E_CAUSE: begin
                stall     = 1'b1;
                csr_write = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = lat_cause;
                state_d   = E_STAT;
            end
            E_STAT: begin
                stall          = 1'b1;
                csr_write      = 1'b1;
                csr_waddr      = ADDR_MSTATUS;
                csr_wdata      = trap_status;
                redirect_valid = 1'b1;
                redirect_pc    = vec_target;
                state_d        = IDLE;
            end
            R_STAT: begin
                stall          = 1'b1;
                csr_write      = 1'b1;
                csr_waddr      = ADDR_MSTATUS;
                csr_wdata      = mret_status;
                redirect_valid = 1'b1;
                redirect_pc    = mepc_sh;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs must read zero for the whole reset window, not just after the next edge.
        if (rst) begin
            csr_write      = 1'b0;
            csr_waddr      = '0;
            csr_wdata      = '0;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
            accept_trap    = 1'b0;
            state_d        = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cause <= '0;
            lat_epc   <= '0;
            lat_intr  <= 1'b0;
            lat_code  <= 4'd0;
        end else if (accept_trap) begin
            lat_cause <= accept_cause;
            lat_epc   <= accept_epc;
            lat_intr  <= accept_intr;
            lat_code  <= accept_cause[3:0];
        end
    end

    // Shadows snoop the write port itself, so the block's own writes are tracked too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_sh <= '0;
            mie_sh     <= '0;
            mtvec_sh   <= '0;
            mepc_sh    <= '0;
        end else if (csr_write) begin
            case (csr_waddr)
                ADDR_MSTATUS: mstatus_sh <= csr_wdata;
                ADDR_MIE:     mie_sh     <= csr_wdata;
                ADDR_MTVEC:   mtvec_sh   <= csr_wdata;
                ADDR_MEPC:    mepc_sh    <= csr_wdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level model of the CSR state and the expected output sequence.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_epc;
    logic        irq_ext, irq_sw, irq_tim;
    logic [31:0] cur_pc;
    logic        mret_valid;
    logic        pipe_csr_we;
    logic [11:0] pipe_csr_waddr;
    logic [31:0] pipe_csr_wdata;
    logic        csr_write;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    trap_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_epc(exc_epc),
        .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_tim(irq_tim),
        .cur_pc(cur_pc), .mret_valid(mret_valid),
        .pipe_csr_we(pipe_csr_we), .pipe_csr_waddr(pipe_csr_waddr),
        .pipe_csr_wdata(pipe_csr_wdata),
        .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          stall;
        bit          we;
        logic [11:0] addr;
        logic [31:0] data;
        bit          rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc;

    int n_checks = 0;
    int n_fail   = 0;

    logic        obs_we, obs_stall, obs_rv;
    logic [11:0] obs_addr;
    logic [31:0] obs_data, obs_rpc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0;
    endtask

    // One cycle of the reference: either the next queued step of a running sequence,
    // or an arbitration decision that expands into the whole expected sequence.
    task automatic model_step(output exp_t e);
        int          code;
        logic [31:0] cause, epc, st, target;
        bit          intr;
        e = '{default: 0};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            code = 0;
            if (m_mstatus[3]) begin
                if (irq_ext && m_mie[11])     code = 11;
                else if (irq_sw && m_mie[3])  code = 3;
                else if (irq_tim && m_mie[7]) code = 7;
            end
            if (exc_valid || code != 0) begin
                intr  = !exc_valid;
                cause = intr ? (32'h8000_0000 + code) : exc_cause;
                epc   = intr ? cur_pc : exc_epc;
                st    = (m_mstatus & ~32'h0000_1888) | (m_mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
                target = m_mtvec & ~32'h3;
                if ((m_mtvec % 4) == 1 && intr) target = target + 4 * code;
                e.stall = 1;
                exp_q.push_back('{1, 1, 12'h341, epc, 0, 0});
                exp_q.push_back('{1, 1, 12'h342, cause, 0, 0});
                exp_q.push_back('{1, 1, 12'h300, st, 1, target});
            end else if (mret_valid) begin
                st = (m_mstatus & ~32'h0000_1888) | (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
                e.stall = 1;
                exp_q.push_back('{1, 1, 12'h300, st, 1, m_mepc});
            end else begin
                e.we   = pipe_csr_we;
                e.addr = pipe_csr_waddr;
                e.data = pipe_csr_wdata;
            end
        end
        if (e.we) begin
            case (e.addr)
                12'h300: m_mstatus = e.data;
                12'h304: m_mie     = e.data;
                12'h305: m_mtvec   = e.data;
                12'h341: m_mepc    = e.data;
                default: ;
            endcase
        end
    endtask

    // Called at posedge+1; inputs are already set for this cycle.
    task automatic step(input string tag);
        exp_t e;
        model_step(e);
        @(negedge clk);
        obs_we = csr_write; obs_addr = csr_waddr; obs_data = csr_wdata;
        obs_stall = stall; obs_rv = redirect_valid; obs_rpc = redirect_pc;
        check({tag, "_stall"}, 32'(obs_stall), 32'(e.stall));
        check({tag, "_we"}, 32'(obs_we), 32'(e.we));
        if (e.we) begin
            check({tag, "_addr"}, 32'(obs_addr), 32'(e.addr));
            check({tag, "_data"}, obs_data, e.data);
        end
        check({tag, "_rv"}, 32'(obs_rv), 32'(e.rv));
        if (e.rv) check({tag, "_rpc"}, obs_rpc, e.rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exc_valid = 0; exc_cause = 0; exc_epc = 0;
        irq_ext = 0; irq_sw = 0; irq_tim = 0; cur_pc = 0;
        mret_valid = 0;
        pipe_csr_we = 0; pipe_csr_waddr = 0; pipe_csr_wdata = 0;
    endtask

    task automatic pipe_write(input string tag, input logic [11:0] a, input logic [31:0] d);
        pipe_csr_we = 1; pipe_csr_waddr = a; pipe_csr_wdata = d;
        step(tag);
        pipe_csr_we = 0; pipe_csr_waddr = 0; pipe_csr_wdata = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(csr_write), 0);
        check({tag, "_addr"}, 32'(csr_waddr), 0);
        check({tag, "_data"}, csr_wdata, 0);
        check({tag, "_stall"}, 32'(stall), 0);
        check({tag, "_rv"}, 32'(redirect_valid), 0);
        check({tag, "_rpc"}, redirect_pc, 0);
    endtask

    logic [11:0] addr_pool [6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h340};

    initial begin
        idle_inputs();
        rst = 1;
        pipe_csr_we = 1; pipe_csr_waddr = 12'h305; pipe_csr_wdata = 32'hFFFF;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        idle_inputs();
        model_reset();
        step("post_reset");

        // Exception entry
        pipe_write("s1_mtvec", 12'h305, 32'h100);
        pipe_write("s1_mstatus", 12'h300, 32'h8);
        exc_valid = 1; exc_cause = 2; exc_epc = 32'h40;
        step("s1_accept");
        check("s1_accept_stall", 32'(obs_stall), 1);
        idle_inputs();
        step("s1_epc");
        check("s1_mepc", obs_data, 32'h40);
        step("s1_cause");
        check("s1_mcause", obs_data, 32'h2);
        step("s1_stat");
        check("s1_mstatus", obs_data, 32'h1880);
        check("s1_rpc", obs_rpc, 32'h100);
        step("s1_after");
        check("s1_after_stall", 32'(obs_stall), 0);

        // MRET
        mret_valid = 1;
        step("s4_accept");
        mret_valid = 0;
        step("s4_stat");
        check("s4_mstatus", obs_data, 32'h1888);
        check("s4_rpc", obs_rpc, 32'h40);

        // Vectored timer interrupt
        pipe_write("s2_mtvec", 12'h305, 32'h101);
        pipe_write("s2_mie", 12'h304, 32'h80);
        pipe_write("s2_mstatus", 12'h300, 32'h8);
        irq_tim = 1; cur_pc = 32'h200;
        step("s2_accept");
        idle_inputs();
        step("s2_epc");
        check("s2_mepc", obs_data, 32'h200);
        step("s2_cause");
        check("s2_mcause", obs_data, 32'h8000_0007);
        step("s2_stat");
        check("s2_rpc", obs_rpc, 32'h11C);

        // Masking, then priority
        pipe_write("s3_mstatus0", 12'h300, 32'h0);
        irq_ext = 1;
        for (int i = 0; i < 3; i++) begin
            step("s3_masked");
            check("s3_masked_stall", 32'(obs_stall), 0);
        end
        irq_sw = 1; irq_tim = 1;
        pipe_write("s3_mie", 12'h304, 32'h888);
        pipe_write("s3_mstatus", 12'h300, 32'h8);
        step("s3_accept");
        idle_inputs();
        step("s3_epc");
        step("s3_cause");
        check("s3_mcause", obs_data, 32'h8000_000B);
        step("s3_stat");

        // Exception colliding with a pipeline write
        exc_valid = 1; exc_cause = 5; exc_epc = 32'h80;
        pipe_csr_we = 1; pipe_csr_waddr = 12'h340; pipe_csr_wdata = 32'hDEAD;
        step("s5_accept");
        check("s5_accept_we", 32'(obs_we), 0);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step("s5_seq");
            check("s5_no_mscratch", 32'(obs_we && obs_addr == 12'h340), 0);
        end

        // Reset in the middle of trap entry
        exc_valid = 1; exc_cause = 1; exc_epc = 32'h99;
        step("s6_accept");
        idle_inputs();
        step("s6_epc");
        rst = 1;
        #1;
        check_all_zero("s6_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step("s6_after");
            check("s6_no_write", 32'(obs_we), 0);
        end
        pipe_write("s6_pass", 12'h305, 32'h1234);
        check("s6_pass_data", obs_data, 32'h1234);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            exc_valid  = ($urandom_range(0, 15) == 0);
            exc_cause  = $urandom & 32'h7FFF_FFFF;
            exc_epc    = $urandom & ~32'h3;
            irq_ext    = ($urandom_range(0, 3) == 0);
            irq_sw     = ($urandom_range(0, 3) == 0);
            irq_tim    = ($urandom_range(0, 3) == 0);
            cur_pc     = $urandom & ~32'h3;
            mret_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 2) == 0) begin
                pipe_csr_we    = 1;
                pipe_csr_waddr = addr_pool[$urandom_range(0, 5)];
                pipe_csr_wdata = $urandom;
            end
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer sitting between the pipeline and the CSR register file; owns the CSR file's single write port.
- Takes exceptions, enabled interrupts and MRET, and serialises the required CSR updates (mepc, mcause, mstatus) over multiple cycles while stalling the pipeline.
- Issues a one-cycle PC redirect to the trap vector or to mepc.
- Forwards ordinary pipeline CSR writes when idle and snoops every write to keep shadow copies of mstatus, mie, mtvec and mepc.

Parameters:
XLEN, 32, data/address width of CSR words and PCs
CSR_AW, 12, CSR address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
exc_valid  in  1  synchronous exception at the commit point
exc_cause  in  XLEN  exception code (bit 31 must be 0)
exc_epc  in  XLEN  PC of the faulting instruction
irq_ext  in  1  machine external interrupt line (code 11)
irq_sw  in  1  machine software interrupt line (code 3)
irq_tim  in  1  machine timer interrupt line (code 7)
cur_pc  in  XLEN  PC of the next instruction to commit, used as mepc for interrupts
mret_valid  in  1  MRET at the commit point
pipe_csr_we  in  1  pipeline CSR write request
pipe_csr_waddr  in  CSR_AW  pipeline CSR write address
pipe_csr_wdata  in  XLEN  pipeline CSR write data
csr_write  out  1  CSR file write enable
csr_waddr  out  CSR_AW  CSR file write address
csr_wdata  out  XLEN  CSR file write data
stall  out  1  freeze the pipeline
redirect_valid  out  1  one-cycle PC redirect strobe
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: all outputs 0, state IDLE, all shadows 0 (matches CSR file reset). Reset mid-sequence aborts immediately; no partial write is issued after reset release.
- CSR addresses:
  - MSTATUS 0x300, MIE 0x304, MTVEC 0x305
  - MEPC 0x341, MCAUSE 0x342
- Shadows: whenever csr_write is 1, the shadow matching csr_waddr is updated with csr_wdata on the clock edge. This covers both pipeline writes and the block's own writes.
- Interrupt take condition: mstatus_sh[3] & ((irq_ext & mie_sh[11]) | (irq_sw & mie_sh[3]) | (irq_tim & mie_sh[7])).
  - Priority: ext > sw > tim.
  - mcause = 0x8000_0000 | code.
- Arbitration in IDLE, evaluated in one cycle in this order:
  1. exc_valid
  2. interrupt take
  3. mret_valid
  4. pipe_csr_we
- Accept cycle (IDLE with an event):
  - Latch cause/epc (epc = exc_epc for exceptions, cur_pc for interrupts) and the interrupt flag.
  - stall = 1, csr_write = 0.
  - Any same-cycle pipe_csr_we is dropped.
- IDLE with no event: csr_write/addr/data pass through pipe_csr_*; stall = 0.
- Trap entry FSM: IDLE -> E_EPC -> E_CAUSE -> E_STAT -> IDLE.
  - E_EPC writes mepc = latched epc.
  - E_CAUSE writes mcause = latched cause.
  - E_STAT writes mstatus = mstatus_sh with MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = 2'b11.
  - E_STAT also asserts redirect_valid for one cycle with redirect_pc:
    - base = {mtvec_sh[31:2], 2'b00}
    - if mtvec_sh[1:0] == 1 and interrupt: base + (code << 2); else base.
  - stall = 1 from the accept cycle through E_STAT inclusive (4 cycles).
- MRET FSM: IDLE -> R_STAT -> IDLE.
  - R_STAT writes mstatus with MIE = MPIE, MPIE = 1, MPP = 2'b11.
  - R_STAT asserts redirect_valid with redirect_pc = mepc_sh.
  - stall = 1 for 2 cycles.
- While not IDLE: exc_valid, irq_*, mret_valid and pipe_csr_we are ignored. The pipeline is stalled and must hold its requests.
- redirect_valid and csr_write are never asserted outside the cycles listed above.
- Writes to other CSR addresses pass through unchanged and are not shadowed.

Test Plan:
1. Exception: reset; pipeline writes mtvec = 0x0000_0100 and mstatus = 0x8. Then exc_valid = 1, exc_cause = 2, exc_epc = 0x40. Required, in consecutive cycles:
   - stall high for 4 cycles
   - writes mepc = 0x40, then mcause = 0x2, then mstatus = 0x1880
   - redirect_valid = 1 with redirect_pc = 0x100 in the last of those cycles
2. Vectored interrupt: mtvec = 0x101, mie = 0x80, mstatus = 0x8, irq_tim = 1, cur_pc = 0x200. Required:
   - mepc = 0x200
   - mcause = 0x8000_0007
   - redirect_pc = 0x11C
3. Masking and priority:
   - mstatus = 0 with irq_ext = 1 -> no trap, stall stays 0.
   - Then mstatus = 0x8, mie = 0x888, all three irq lines high -> mcause = 0x8000_000B.
4. MRET: after scenario 1 (mstatus = 0x1880), mret_valid = 1. Required:
   - stall for 2 cycles
   - write mstatus = 0x1888
   - redirect_pc = 0x40
5. Collision: exc_valid and pipe_csr_we (MSCRATCH, 0xDEAD) in the same cycle -> the MSCRATCH write never appears on csr_write; the trap sequence completes normally.
6. Reset mid-sequence: assert rst during E_CAUSE. Required:
   - all outputs 0 immediately
   - after rst deassert: no mcause/mstatus write, stall = 0, passthrough works
